// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write control slice.
// Provides the controller state encoding, the requester grant IDs and the
// architectural register constants used by the write arbiter.
package rf_ctrl_pkg;

  typedef enum logic {StInit, StRun} state_e;

  typedef enum logic {GrantEx, GrantLd} grant_e;

  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam logic [4:0]  X0_ADDR       = 5'd0;
  localparam logic [4:0]  LAST_REG_ADDR = 5'(NUM_ARCH_REGS - 1);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter for the register-file write port.
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   en                  arbitration enable (only grants while high)
//   ex_valid, ld_valid  requests from execute and load writeback
//   ex_ready, ld_ready  combinational one-hot grants
// PRIO_MODE = 0 alternates between requesters on conflict; 1 makes ld win.
module rr_arbiter2
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ex_valid,
  input  logic ld_valid,
  output logic ex_ready,
  output logic ld_ready
);

  grant_e last_grant_q, last_grant_d;

  always_comb begin
    ex_ready     = 1'b0;
    ld_ready     = 1'b0;
    last_grant_d = last_grant_q;
    if (en) begin
      if (ex_valid && ld_valid) begin
        // On conflict the requester that did not win last time goes next.
        if ((PRIO_MODE != 0) || (last_grant_q == GrantEx)) begin
          ld_ready = 1'b1;
        end else begin
          ex_ready = 1'b1;
        end
      end else if (ex_valid) begin
        ex_ready = 1'b1;
      end else if (ld_valid) begin
        ld_ready = 1'b1;
      end
    end
    // A grant always implies a transfer since ready is only raised with valid.
    if (ex_ready) begin
      last_grant_d = GrantEx;
    end else if (ld_ready) begin
      last_grant_d = GrantLd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= GrantEx;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owner of the register-file write port.
// After reset it clears x1..x31 through the port, then shares the port
// between execute (ex) and load (ld) writeback using valid/ready.
// Ports:
//   clk, reset                    clock and synchronous active-low reset
//   ex_valid/addr/data, ex_ready  execute writeback request and grant
//   ld_valid/addr/data, ld_ready  load writeback request and grant
//   rf_we, rf_waddr, rf_wdata     registered register-file write port
//   init_done                     clear sequence finished
//   conflict_cnt                  saturating count of RUN cycles with both valid
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [4:0]       ex_addr,
  input  logic [N-1:0]     ex_data,
  output logic             ex_ready,
  input  logic             ld_valid,
  input  logic [4:0]       ld_addr,
  input  logic [N-1:0]     ld_data,
  output logic             ld_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [N-1:0]     rf_wdata,
  output logic             init_done,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e     state_q;
  logic [4:0] init_ptr_q;
  logic       arb_en;
  logic       ex_xfer;
  logic       ld_xfer;

  assign arb_en  = (state_q == StRun);
  assign ex_xfer = ex_valid & ex_ready;
  assign ld_xfer = ld_valid & ld_ready;

  rr_arbiter2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (arb_en),
    .ex_valid (ex_valid),
    .ld_valid (ld_valid),
    .ex_ready (ex_ready),
    .ld_ready (ld_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StInit;
      init_ptr_q   <= 5'd1;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      init_done    <= 1'b0;
      conflict_cnt <= '0;
    end else if (state_q == StInit) begin
      rf_we    <= 1'b1;
      rf_waddr <= init_ptr_q;
      rf_wdata <= '0;
      if (init_ptr_q == LAST_REG_ADDR) begin
        state_q   <= StRun;
        init_done <= 1'b1;
      end else begin
        init_ptr_q <= init_ptr_q + 5'd1;
      end
    end else begin
      if (ex_xfer) begin
        rf_we    <= (ex_addr != X0_ADDR);
        rf_waddr <= ex_addr;
        rf_wdata <= ex_data;
      end else if (ld_xfer) begin
        rf_we    <= (ld_addr != X0_ADDR);
        rf_waddr <= ld_addr;
        rf_wdata <= ld_data;
      end else begin
        // Address and data hold; only the enable drops.
        rf_we <= 1'b0;
      end
      if (ex_valid && ld_valid && (conflict_cnt != CntMax)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the 32-entry register file in the single-cycle RISC-V core.
- After reset, sequences a hardware clear of x1..x31 through that write port.
- Afterwards, shares the write port between two requesters: execute writeback (ex) and load writeback (ld).
- Each requester uses a valid/ready handshake. All register-file write signals are registered.

Parameters:
- N, 32, data width; matches register-file width.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with ld over ex.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
- ex_valid  in  1  execute writeback request.
- ex_addr  in  5  execute destination register.
- ex_data  in  N  execute write data.
- ex_ready  out  1  execute request accepted this cycle.
- ld_valid  in  1  load writeback request.
- ld_addr  in  5  load destination register.
- ld_data  in  N  load write data.
- ld_ready  out  1  load request accepted this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  N  register-file write data (registered).
- init_done  out  1  high once the clear sequence has completed.
- conflict_cnt  out  CNT_W  count of cycles with both requests valid in RUN; saturates.

Behaviour:
- Reset (reset==0 at posedge):
  - state=INIT, init_ptr=1, last_grant=EX.
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, conflict_cnt=0.
  - ex_ready and ld_ready are low in INIT, so they are low after reset.
- Reset asserted mid-INIT or mid-RUN aborts the current activity and restarts INIT from x1. Any accepted but unissued write is discarded; only the registered output stage holds such a write.
- State INIT:
  - Each cycle: register rf_we=1, rf_waddr=init_ptr, rf_wdata=0, then init_ptr++.
  - After issuing init_ptr==31: go to RUN and set init_done=1 on that same edge.
  - ex_ready=ld_ready=0 throughout; valids are ignored and not counted.
  - First clear write is visible on rf_* in the cycle after reset deasserts. Clear writes occupy 31 consecutive cycles.
- State RUN, grant logic (combinational, same cycle):
  - Only one valid: that requester gets ready=1.
  - Both valid, PRIO_MODE=0: grant the requester not in last_grant.
  - Both valid, PRIO_MODE=1: ld always wins.
  - Neither valid: no grant, last_grant unchanged.
  - At most one of ex_ready/ld_ready is high in any cycle.
- Handshake:
  - Transfer occurs when valid && ready at a posedge.
  - A requester must hold valid, addr and data stable until ready.
  - ready never depends on the other side's ready.
- Issue on transfer (next posedge):
  - rf_waddr and rf_wdata take the granted addr/data.
  - rf_we=1, except rf_we=0 when addr==0 (x0 writes are accepted and dropped).
  - last_grant is updated to the winner, including for x0 writes.
  - No transfer: rf_we=0; rf_waddr and rf_wdata hold their previous values.
- Latency: exactly 1 cycle from accept to rf_we. Throughput is one write per cycle, sustained.
- Same address on both sides in one cycle: arbitrated normally. The loser writes the following cycle (or later) and its value is final.
- conflict_cnt increments in RUN on every cycle with ex_valid && ld_valid. It holds at 2^CNT_W-1 and never wraps.
- init_done stays 1 until the next reset.

Decomposition:
- Shared package rf_ctrl_pkg:
  - state encoding INIT/RUN.
  - grant IDs EX/LD.
  - constant NUM_ARCH_REGS=32.
  - constant X0_ADDR=5'd0.
- One natural sub-module: rr_arbiter2. It is a 2-requester arbiter with a PRIO_MODE parameter, a last_grant register and ready outputs; it is enabled only in RUN.
- The INIT sequencer, output register stage and conflict counter stay in the top module.

Test Plan:
- Init sequence: hold reset=0 for 2 cycles, then release -> rf_we=1 for 31 consecutive cycles with rf_waddr 1..31 and rf_wdata=0; init_done rises on the last clear write's edge; ex_ready=ld_ready=0 throughout even with ex_valid=1.
- Single requester: in RUN, ex_valid=1, ex_addr=5, ex_data=32'hDEADBEEF for 1 cycle -> ex_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF; following cycle rf_we=0.
- Round-robin: PRIO_MODE=0, both valid continuously (ex addr 3, ld addr 4) for 4 cycles right after init -> grants ld, ex, ld, ex; rf_waddr 4,3,4,3; conflict_cnt=4.
- Fixed priority and x0 drop: PRIO_MODE=1, both valid for 3 cycles -> ld granted every cycle and ex_ready=0. Separately, ld_addr=0, ld_data=32'h1 -> ld_ready=1 and next cycle rf_we=0.
- Reset mid-operation: assert reset=0 during the INIT cycle writing x10, release -> clears restart at x1, x1..x31 rewritten, init_done=0 until the new sequence completes.
- Saturation: CNT_W=3, both valid for 10 RUN cycles -> conflict_cnt reaches 7 and holds at 7.
